div_clk_gen: RTL
================

# div_clk_gen

Parametrised, runtime-programmable clock/enable generator that replaces the fixed 1 Hz divider in the board designs. It produces a duty-programmable divided square wave plus a one-cycle tick per period, all in the `clk` domain. Divisor and high-time can be reprogrammed while running, and take effect glitch-free at the period boundary. Start and stop are controlled by an enable, and stop is clean (the current period always completes).

## Interface
- `CNT_W`, 24 — counter and config width.
- `DIV_DEFAULT`, 12000000 — reset divisor in `clk` cycles (1 s at 12 MHz).
- `DUTY_DEFAULT`, `DIV_DEFAULT/2` — reset high-time in cycles.

- `clk` in 1 — system clock.
- `rst` in 1 — asynchronous, active-high reset.
- `en` in 1 — run request (level).
- `cfg_div` in `CNT_W` — requested period in cycles.
- `cfg_high` in `CNT_W` — requested high-time in cycles.
- `cfg_load` in 1 — one-cycle strobe; captures `cfg_div`/`cfg_high`.
- `cfg_ack` out 1 — one-cycle pulse when the new config becomes active.
- `clk_out` out 1 — divided waveform, registered.
- `tick` out 1 — one-cycle pulse on the first cycle of each period.
- `running` out 1 — high in RUN and STOP.

## Operation
- Active registers: `div_r`, `high_r`. Counter `cnt` runs 0..`div_r`-1, then wraps to 0.
- Each output cycle reflects that cycle's `cnt`:
  - `clk_out` = (`cnt` >= `div_r`-`high_r`), i.e. low first, high for the last `high_r` cycles.
  - `tick` = (`cnt`==0).
- Sanitisation at capture:
  - `cfg_div` < 2 is clamped to 2.
  - `cfg_high` > divisor is clamped to the divisor.
  - `high`=0 gives constant low; `high`=`div` gives constant high. `tick` still pulses in both cases.
- `cfg_load` writes a shadow register and sets `pending`.
  - A second load while pending overwrites the shadow. Only the latest value is applied, with a single `cfg_ack`.
  - Transfer to the active registers happens in IDLE on the next cycle, or in RUN/STOP on the cycle `cnt` wraps to 0. `cfg_ack` pulses on the transfer cycle.
  - Load coincident with a wrap: that load is applied at the following wrap.
- FSM:
  - IDLE → RUN when `en`=1.
  - RUN → STOP when `en`=0.
  - STOP → RUN when `en`=1 (no interruption of count or waveform).
  - STOP → IDLE after the cycle with `cnt`==`div_r`-1.
- In IDLE: `cnt`=0, `clk_out`=0, `tick`=0, `running`=0.

## Timing
- Reset (async, immediate, no clock needed):
  - `clk_out`=0, `tick`=0, `cfg_ack`=0, `running`=0.
  - `cnt`=0, state IDLE, `pending`=0.
  - `div_r`=`DIV_DEFAULT`, `high_r`=`DUTY_DEFAULT`.
- Start: `en` sampled high at edge k → cycle k+1 is the first RUN cycle, with `cnt`=0, `tick`=1 and `running`=1.
- Period: exactly `div_r` cycles between ticks. `clk_out` is high for exactly `high_r` cycles per period.
- Stop: the last period always completes. `running` falls and `clk_out` is 0 on the cycle after `cnt`==`div_r`-1.
- Reconfiguration never produces a truncated or stretched period.
- Reset mid-period aborts the period immediately. No completion is owed.

## Configuration
- `DIV_CLK_SYNC_EN` defined:
  - `en` passes through a 2-flop synchronizer (reset 0) before the FSM.
  - Start and stop latency increase by 2 cycles; `en` may be asynchronous.
- Not defined: `en` is used directly and must be synchronous to `clk`.

## Test plan
Bench setup: `CNT_W`=8, `DIV_DEFAULT`=10, `DUTY_DEFAULT`=5, macro undefined unless stated.
- Release reset, then `en`=1 → `tick` every 10 cycles; `clk_out` 5 low / 5 high; first `tick` 1 cycle after `en` is sampled.
- While running, at `cnt`=3, `cfg_load` with div=4, high=1 → current period still lasts 10 cycles; `cfg_ack` on the wrap cycle; then period 4 with `clk_out` pattern 0,0,0,1.
- `cfg_load` div=1, high=7 → active div=2, high=2; `clk_out` constant 1; `tick` every 2 cycles.
- Drop `en` at `cnt`=2 → counts to 9, then `running`=0 and `clk_out`=0; repeat, re-raising `en` at `cnt`=6 → no gap, next `tick` at the normal wrap.
- Assert `rst` mid high-phase, between clock edges → outputs 0 immediately; after release, period is back to 10.
- With `DIV_CLK_SYNC_EN` → first `tick` 3 cycles after `en` rises; stop is deferred by 2 cycles.

Source files
------------

// File: rtl/div_clk_gen.sv
// -----------------------------------------------------------------------------
// div_clk_gen
//
// Runtime-programmable clock/enable generator. Produces a divided square wave
// (low first, then high for the last high_r cycles of each period) and a
// one-cycle tick on the first cycle of every period, all in the clk domain.
// New divisor/high-time values are staged in a shadow register and only move
// into the active registers at a period boundary (or immediately when idle),
// so a running waveform never sees a truncated or stretched period. Dropping
// en lets the current period finish before the generator goes idle.
//
// Optional feature macro: DIV_CLK_SYNC_EN
//   defined     -> en passes through a 2-flop synchronizer (reset 0) before
//                  the FSM; start/stop latency grows by 2 cycles.
//   not defined -> en is used directly and must be synchronous to clk.
//
// Parameters
//   CNT_W        counter and config width
//   DIV_DEFAULT  reset divisor in clk cycles
//   DUTY_DEFAULT reset high-time in clk cycles
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous, active-high reset
//   en         in   run request (level)
//   cfg_div    in   requested period in cycles (values < 2 clamp to 2)
//   cfg_high   in   requested high-time (values > divisor clamp to divisor)
//   cfg_load   in   one-cycle strobe capturing cfg_div/cfg_high
//   cfg_ack    out  one-cycle pulse on the cycle the new config becomes active
//   clk_out    out  divided waveform, registered
//   tick       out  one-cycle pulse on the first cycle of each period
//   running    out  high while in RUN or STOP
//   dbg_state  out  current FSM state (0 IDLE, 1 RUN, 2 STOP)
//
// Handshake: cfg_load has no ready; a load is always accepted. Any number of
// loads before the next boundary collapse into one transfer with one cfg_ack.
// -----------------------------------------------------------------------------
module div_clk_gen #(
    parameter int unsigned CNT_W        = 24,
    parameter int unsigned DIV_DEFAULT  = 12000000,
    parameter int unsigned DUTY_DEFAULT = DIV_DEFAULT / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic             cfg_load,
    output logic             cfg_ack,
    output logic             clk_out,
    output logic             tick,
    output logic             running,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DIV_INIT  = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0] HIGH_INIT = CNT_W'(DUTY_DEFAULT);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO       = CNT_W'(2);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] div_r, div_n;
    logic [CNT_W-1:0] high_r, high_n;
    logic [CNT_W-1:0] sh_div, sh_high;
    logic [CNT_W-1:0] cap_div, cap_high;
    logic             pending, pending_n;
    logic             wrap;
    logic             xfer;
    logic             active_n;
    logic             en_fsm;

`ifdef DIV_CLK_SYNC_EN
    logic en_meta, en_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_meta <= 1'b0;
            en_sync <= 1'b0;
        end else begin
            en_meta <= en;
            en_sync <= en_meta;
        end
    end

    assign en_fsm = en_sync;
`else
    assign en_fsm = en;
`endif

    // Sanitise at capture so the active registers always hold a legal pair
    // (div >= 2, high <= div); the waveform compare relies on that.
    always_comb begin
        cap_div  = (cfg_div < TWO) ? TWO : cfg_div;
        cap_high = (cfg_high > cap_div) ? cap_div : cfg_high;
    end

    // Last cycle of the current period.
    assign wrap = (cnt >= div_r - ONE);

    // Shadow moves into the active registers when idle, or at the edge that
    // takes cnt back to 0. A load sampled on that same edge sets pending
    // again and therefore lands on the following boundary.
    assign xfer = pending && ((state == ST_IDLE) || wrap);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (en_fsm) begin
                    state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_n = wrap ? '0 : cnt + ONE;
                if (!en_fsm) begin
                    // Stop request on the last cycle: the period is already
                    // complete, so go straight to idle.
                    state_n = wrap ? ST_IDLE : ST_STOP;
                end
            end
            ST_STOP: begin
                cnt_n = wrap ? '0 : cnt + ONE;
                if (en_fsm) begin
                    state_n = ST_RUN;
                end else if (wrap) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_comb begin
        div_n     = xfer ? sh_div : div_r;
        high_n    = xfer ? sh_high : high_r;
        pending_n = cfg_load | (pending & ~xfer);
        active_n  = (state_n != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            div_r   <= DIV_INIT;
            high_r  <= HIGH_INIT;
            sh_div  <= DIV_INIT;
            sh_high <= HIGH_INIT;
            pending <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            div_r   <= div_n;
            high_r  <= high_n;
            pending <= pending_n;
            if (cfg_load) begin
                sh_div  <= cap_div;
                sh_high <= cap_high;
            end
        end
    end

    // Outputs are registered from next-cycle values so each output cycle
    // reflects that same cycle's cnt and active configuration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_out <= 1'b0;
            tick    <= 1'b0;
            running <= 1'b0;
            cfg_ack <= 1'b0;
        end else begin
            clk_out <= active_n && (cnt_n >= div_n - high_n);
            tick    <= active_n && (cnt_n == '0);
            running <= active_n;
            cfg_ack <= xfer;
        end
    end

    assign dbg_state = state;

endmodule
